// File: rtl/register_file_mp.sv
// Multi-port integer register file with an optional hard-wired zero register,
// same-cycle write-to-read forwarding and a per-register pending scoreboard.
module register_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 1,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_WRITE-1:0]           we,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wa,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] wd,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]  ra,
  output logic [NUM_READ*DATA_WIDTH-1:0]  rd,
  output logic [NUM_READ-1:0]            rd_pending,
  input  logic                           issue_valid,
  input  logic [ADDR_WIDTH-1:0]          issue_rd,
  output logic                           any_pending
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0]      pending_reg;
  logic [DEPTH-1:0]      pending_next;

  logic [ADDR_WIDTH-1:0] wa_arr [NUM_WRITE];
  logic [DATA_WIDTH-1:0] wd_arr [NUM_WRITE];
  logic [NUM_WRITE-1:0]  we_eff;
  logic [NUM_WRITE-1:0]  we_store;

  // Reset masks writes everywhere, including the forwarding path.
  assign we_eff = rst ? '0 : we;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WRITE; gi++) begin : g_wport
      assign wa_arr[gi]   = wa[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wd_arr[gi]   = wd[gi*DATA_WIDTH +: DATA_WIDTH];
      assign we_store[gi] = we_eff[gi] && !((ZERO_REG != 0) && (wa_arr[gi] == '0));
    end
  endgenerate

  // Ascending port order makes the highest-indexed port win on collisions.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_reg[k] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_WRITE; i++) begin
        if (we_store[i]) begin
          mem_reg[wa_arr[i]] <= wd_arr[i];
        end
      end
    end
  end

  // Writeback clears first, issue sets last: the younger producer wins.
  always_comb begin
    pending_next = pending_reg;
    for (int i = 0; i < NUM_WRITE; i++) begin
      if (we_eff[i]) begin
        pending_next[wa_arr[i]] = 1'b0;
      end
    end
    if (issue_valid && !((ZERO_REG != 0) && (issue_rd == '0))) begin
      pending_next[issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  assign any_pending = |pending_reg;

  generate
    for (gi = 0; gi < NUM_READ; gi++) begin : g_rport
      logic [ADDR_WIDTH-1:0] ra_port;
      logic [DATA_WIDTH-1:0] rd_port;
      logic                  pend_port;

      assign ra_port = ra[gi*ADDR_WIDTH +: ADDR_WIDTH];

      always_comb begin
        rd_port   = mem_reg[ra_port];
        pend_port = pending_reg[ra_port];
        if (BYPASS != 0) begin
          for (int i = 0; i < NUM_WRITE; i++) begin
            if (we_eff[i] && (wa_arr[i] == ra_port)) begin
              rd_port   = wd_arr[i];
              pend_port = 1'b0;
            end
          end
        end
        if ((ZERO_REG != 0) && (ra_port == '0)) begin
          rd_port   = '0;
          pend_port = 1'b0;
        end
      end

      assign rd[gi*DATA_WIDTH +: DATA_WIDTH] = rd_port;
      assign rd_pending[gi]                  = pend_port;
    end
  endgenerate

endmodule

// File: tb/tb_register_file_mp.sv
// Directed vector bench: a forwarding instance and a non-forwarding instance
// share stimulus; outputs are checked just before each rising edge.
module tb_register_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      we;
  logic [2*AW-1:0] wa;
  logic [2*DW-1:0] wd;
  logic [2*AW-1:0] ra;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic [2*DW-1:0] rd_b, rd_n;
  logic [1:0]      rdp_b, rdp_n;
  logic            any_b, any_n;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  register_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(2), .NUM_WRITE(2),
                     .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_b),
    .rd_pending(rdp_b), .issue_valid(issue_valid), .issue_rd(issue_rd), .any_pending(any_b));

  register_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(2), .NUM_WRITE(2),
                     .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_n),
    .rd_pending(rdp_n), .issue_valid(issue_valid), .issue_rd(issue_rd), .any_pending(any_n));

  typedef struct {
    logic            rst;
    logic [1:0]      we;
    logic [AW-1:0]   wa0, wa1;
    logic [DW-1:0]   wd0, wd1;
    logic            iv;
    logic [AW-1:0]   ird;
    logic [AW-1:0]   ra0, ra1;
    logic [DW-1:0]   e_rd0, e_rd1;
    logic            e_p0, e_any;
    logic [DW-1:0]   e_nrd0;
    logic            e_np0;
  } vec_t;

  vec_t vecs [23];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] w, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic iv, input logic [AW-1:0] ird, input logic [AW-1:0] r0,
                       input logic [AW-1:0] r1);
    rst = r; we = w; wa = {a1, a0}; wd = {d1, d0};
    issue_valid = iv; issue_rd = ird; ra = {r1, r0};
  endtask

  function automatic vec_t mk(logic r, logic [1:0] w, logic [AW-1:0] a0, logic [DW-1:0] d0,
                              logic [AW-1:0] a1, logic [DW-1:0] d1, logic iv, logic [AW-1:0] ird,
                              logic [AW-1:0] r0, logic [AW-1:0] r1, logic [DW-1:0] erd0,
                              logic [DW-1:0] erd1, logic ep0, logic eany, logic [DW-1:0] enrd0,
                              logic enp0);
    vec_t v;
    v.rst = r; v.we = w; v.wa0 = a0; v.wd0 = d0; v.wa1 = a1; v.wd1 = d1;
    v.iv = iv; v.ird = ird; v.ra0 = r0; v.ra1 = r1;
    v.e_rd0 = erd0; v.e_rd1 = erd1; v.e_p0 = ep0; v.e_any = eany;
    v.e_nrd0 = enrd0; v.e_np0 = enp0;
    return v;
  endfunction

  initial begin
    //            rst we   wa0 wd0           wa1 wd1       iv ird ra0 ra1 rd0           rd1           p0 any nrd0          np0
    vecs[0]  = mk(0, 2'b01, 5, 32'hDEADBEEF, 0, 0,           0, 0,  5,  5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 32'h0,        0);
    vecs[1]  = mk(1, 2'b00, 0, 0,            0, 0,           0, 0,  5,  0, 32'hDEADBEEF, 32'h0,        0, 0, 32'hDEADBEEF, 0);
    vecs[2]  = mk(0, 2'b00, 0, 0,            0, 0,           0, 0,  5,  0, 32'h0,        32'h0,        0, 0, 32'h0,        0);
    vecs[3]  = mk(0, 2'b01, 0, 32'h12345678, 0, 0,           1, 0,  0,  0, 32'h0,        32'h0,        0, 0, 32'h0,        0);
    vecs[4]  = mk(0, 2'b00, 0, 0,            0, 0,           0, 0,  0,  0, 32'h0,        32'h0,        0, 0, 32'h0,        0);
    vecs[5]  = mk(0, 2'b01, 7, 32'hA5A5A5A5, 0, 0,           0, 0,  7,  0, 32'hA5A5A5A5, 32'h0,        0, 0, 32'h0,        0);
    vecs[6]  = mk(0, 2'b00, 0, 0,            0, 0,           0, 0,  7,  0, 32'hA5A5A5A5, 32'h0,        0, 0, 32'hA5A5A5A5, 0);
    vecs[7]  = mk(0, 2'b00, 0, 0,            0, 0,           1, 3,  3,  0, 32'h0,        32'h0,        0, 0, 32'h0,        0);
    vecs[8]  = mk(0, 2'b00, 0, 0,            0, 0,           0, 0,  3,  0, 32'h0,        32'h0,        1, 1, 32'h0,        1);
    vecs[9]  = mk(0, 2'b01, 3, 32'h42,       0, 0,           0, 0,  3,  0, 32'h42,       32'h0,        0, 1, 32'h0,        1);
    vecs[10] = mk(0, 2'b00, 0, 0,            0, 0,           0, 0,  3,  0, 32'h42,       32'h0,        0, 0, 32'h42,       0);
    vecs[11] = mk(0, 2'b11, 9, 32'h1,        9, 32'h2,       1, 9,  9,  9, 32'h2,        32'h2,        0, 0, 32'h0,        0);
    vecs[12] = mk(0, 2'b00, 0, 0,            0, 0,           0, 0,  9,  0, 32'h2,        32'h0,        1, 1, 32'h2,        1);
    vecs[13] = mk(1, 2'b01, 4, 32'h77,       0, 0,           1, 4,  9,  0, 32'h2,        32'h0,        1, 1, 32'h2,        1);
    vecs[14] = mk(0, 2'b00, 0, 0,            0, 0,           0, 0,  4,  9, 32'h0,        32'h0,        0, 0, 32'h0,        0);
    vecs[15] = mk(0, 2'b11, 11, 32'hBEEF,    10, 32'hCAFE,   0, 0, 10, 11, 32'hCAFE,     32'hBEEF,     0, 0, 32'h0,        0);
    vecs[16] = mk(0, 2'b00, 0, 0,            0, 0,           0, 0, 11, 10, 32'hBEEF,     32'hCAFE,     0, 0, 32'hBEEF,     0);
    vecs[17] = mk(0, 2'b00, 0, 0,            0, 0,           1, 10, 10, 0, 32'hCAFE,     32'h0,        0, 0, 32'hCAFE,     0);
    vecs[18] = mk(0, 2'b00, 0, 0,            0, 0,           1, 10, 10, 0, 32'hCAFE,     32'h0,        1, 1, 32'hCAFE,     1);
    vecs[19] = mk(0, 2'b01, 10, 32'h5,       0, 0,           1, 10, 10, 0, 32'h5,        32'h0,        0, 1, 32'hCAFE,     1);
    vecs[20] = mk(0, 2'b00, 0, 0,            0, 0,           0, 0, 10,  0, 32'h5,        32'h0,        1, 1, 32'h5,        1);
    vecs[21] = mk(0, 2'b01, 10, 32'h6,       0, 0,           0, 0, 10,  0, 32'h6,        32'h0,        0, 1, 32'h5,        1);
    vecs[22] = mk(0, 2'b00, 0, 0,            0, 0,           0, 0, 10,  0, 32'h6,        32'h0,        0, 0, 32'h6,        0);

    drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);

    // Reset state
    @(negedge clk);
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 31);
    #4;
    check("reset_rd0", rd_b[DW-1:0], 32'h0);
    check("reset_rd1", rd_b[2*DW-1:DW], 32'h0);
    check("reset_pend", {30'h0, rdp_b}, 32'h0);
    check("reset_any", {31'h0, any_b}, 32'h0);
    $display("[TB] reset state checked");

    for (int n = 0; n < 23; n++) begin
      @(negedge clk);
      drive(vecs[n].rst, vecs[n].we, vecs[n].wa0, vecs[n].wd0, vecs[n].wa1, vecs[n].wd1,
            vecs[n].iv, vecs[n].ird, vecs[n].ra0, vecs[n].ra1);
      #4;
      check($sformatf("v%0d_rd0", n), rd_b[DW-1:0], vecs[n].e_rd0);
      check($sformatf("v%0d_rd1", n), rd_b[2*DW-1:DW], vecs[n].e_rd1);
      check($sformatf("v%0d_pend0", n), {31'h0, rdp_b[0]}, {31'h0, vecs[n].e_p0});
      check($sformatf("v%0d_any", n), {31'h0, any_b}, {31'h0, vecs[n].e_any});
      check($sformatf("v%0d_nb_rd0", n), rd_n[DW-1:0], vecs[n].e_nrd0);
      check($sformatf("v%0d_nb_pend0", n), {31'h0, rdp_n[0]}, {31'h0, vecs[n].e_np0});
      $display("[TB] vec %0d rst=%0b we=%b ra0=%0d rd0=0x%08h pend0=%0b any=%0b",
               n, vecs[n].rst, vecs[n].we, vecs[n].ra0, rd_b[DW-1:0], rdp_b[0], any_b);
    end

    // Two outstanding producers: any_pending must hold until the last writeback.
    @(negedge clk);
    drive(0, 2'b00, 0, 0, 0, 0, 1, 31, 31, 1);
    @(negedge clk);
    drive(0, 2'b00, 0, 0, 0, 0, 1, 1, 31, 1);
    #4;
    check("seq_p31", {31'h0, rdp_b[0]}, 32'h1);
    check("seq_p1_not_yet", {31'h0, rdp_b[1]}, 32'h0);
    @(negedge clk);
    drive(0, 2'b10, 0, 0, 31, 32'h99, 0, 0, 31, 1);
    #4;
    check("seq_wb31_fwd", rd_b[DW-1:0], 32'h99);
    check("seq_wb31_pend", {30'h0, rdp_b}, 32'h2);
    check("seq_any_a", {31'h0, any_b}, 32'h1);
    @(negedge clk);
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 31, 1);
    #4;
    check("seq_any_b", {31'h0, any_b}, 32'h1);
    check("seq_pend_b", {30'h0, rdp_b}, 32'h2);
    @(negedge clk);
    drive(0, 2'b01, 1, 32'h11, 0, 0, 0, 0, 31, 1);
    @(negedge clk);
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 31, 1);
    #4;
    check("seq_any_c", {31'h0, any_b}, 32'h0);
    check("seq_rd1", rd_b[2*DW-1:DW], 32'h11);
    check("seq_rd0", rd_b[DW-1:0], 32'h99);
    $display("[TB] scoreboard drain sequence checked");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
Parametrised multi-port successor to the core's 2R/1W integer register file. It adds:
- configurable data width, depth and read/write port counts;
- optional hard-wired zero register;
- same-cycle write-to-read bypass;
- synchronous clear of the whole array on reset;
- a per-register pending (scoreboard) bit, set when an instruction issues and cleared at writeback.

It sits between decode (read ports, issue) and writeback (write ports) in the pipelined / dual-issue core.

Parameters:
DATA_WIDTH, 32, bits per register
ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
NUM_READ, 2, number of read ports (1..4)
NUM_WRITE, 1, number of write ports (1..2)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never pending
BYPASS, 1, 1 = read of a register being written this cycle returns the write data

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
we  in  NUM_WRITE  write enable per write port
wa  in  NUM_WRITE*ADDR_WIDTH  write address, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
wd  in  NUM_WRITE*DATA_WIDTH  write data, same packing
ra  in  NUM_READ*ADDR_WIDTH  read address per port
rd  out  NUM_READ*DATA_WIDTH  read data per port, combinational
rd_pending  out  NUM_READ  1 = addressed register awaits a writeback (data stale)
issue_valid  in  1  marks issue_rd as the destination of a newly issued instruction
issue_rd  in  ADDR_WIDTH  destination register to mark pending
any_pending  out  1  OR of all pending bits (pipeline drain / fence use)

Behaviour:
- Storage: depth x DATA_WIDTH array plus depth x 1 pending vector.
- Reset:
  - When rst is high at a clock edge, every register is set to 0 and every pending bit to 0.
  - While rst is high, we and issue_valid are ignored.
  - The cycle after reset: all rd = 0, rd_pending = 0, any_pending = 0.
  - A reset asserted mid-operation discards in-flight writes and issues on that edge.
- Writes:
  - On a rising edge with we[i]=1, register wa[i] receives wd[i].
  - If ZERO_REG=1 and wa[i]=0, the write is dropped.
  - Two write ports hitting the same address in one cycle: the higher port index wins, for both data and bypass.
- Reads: rd[j] is combinational from ra[j] with zero added latency. Priority, highest first:
  1. ZERO_REG=1 and ra[j]=0 -> rd[j] = 0.
  2. BYPASS=1 and some we[i]=1 with wa[i]=ra[j] -> rd[j] = wd of the winning port.
  3. Otherwise -> array contents.
- Pending (scoreboard):
  - Rising edge with issue_valid=1 sets pending[issue_rd].
  - Rising edge with we[i]=1 clears pending[wa[i]].
  - Issue and write to the same register in the same cycle: set wins; pending stays 1, because the new producer is younger.
  - ZERO_REG=1: pending[0] is never set.
  - Repeated issue to an already-pending register keeps it at 1. There is no counter; the core guarantees in-order writeback per register.
- rd_pending[j]:
  - Equals pending[ra[j]].
  - Forced to 0 when the BYPASS=1 forwarding condition for port j holds, since the data is being produced now.
  - Forced to 0 for reg 0 when ZERO_REG=1.
  - With BYPASS=0, rd_pending[j] reflects the stored bit even during a matching write; the data becomes valid next cycle.
- any_pending: registered view of the pending vector after the edge, with no same-cycle bypass.
- Latency:
  - Write -> visible via array: next cycle.
  - Write -> visible via bypass: same cycle.
  - Issue -> pending visible: next cycle.
- No X propagation: all outputs are defined from reset onward.

Test Plan:
- Reset clears array: write 0xDEADBEEF to x5, then assert rst for 1 cycle -> next cycle ra0=5 gives rd0=0, rd_pending0=0, any_pending=0.
- Zero register (ZERO_REG=1): we=1, wa=0, wd=0x12345678, plus issue_valid=1 with issue_rd=0 -> ra=0 reads 0, rd_pending=0, any_pending stays 0.
- Bypass (BYPASS=1): same cycle we=1, wa=7, wd=0xA5A5A5A5, ra0=7 -> rd0=0xA5A5A5A5 combinationally. With BYPASS=0 the old value 0 is returned and 0xA5A5A5A5 appears next cycle.
- Scoreboard:
  - issue_valid with issue_rd=3 -> next cycle rd_pending for ra=3 is 1 and any_pending=1.
  - Writeback we=1, wa=3, wd=0x42 -> same cycle rd_pending=0 with rd=0x42 (BYPASS=1); next cycle pending[3]=0 and any_pending=0.
- Simultaneous events:
  - NUM_WRITE=2, both ports write reg 9 (0x1 and 0x2) -> reads 0x2.
  - Same cycle issue_rd=9 -> pending[9]=1 after the edge.
- Reset mid-operation: rst=1 together with we=1, wa=4 and issue_valid=1, issue_rd=4 -> next cycle x4=0 and pending[4]=0.
